// File: rtl/div_meter_pkg.sv
// rtl/div_meter_pkg.sv - shared states, defaults and saturation constant for the divided-clock period meter
package div_meter_pkg;

  localparam int CNT_W_DEF       = 12;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    HOLD
  } state_t;

  function automatic logic [31:0] sat_val(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser with history flop giving rise/fall strobes
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_async,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_async};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~hist_q;
  assign fall  = ~sig_s & hist_q;

endmodule

// File: rtl/div_period_meter.sv
// rtl/div_period_meter.sv - measures period and high time of an asynchronous divided clock in clk cycles
module div_period_meter
  import div_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             measure_en,
  input  logic             period_ready,
  output logic             period_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             ovf,
  output logic             edge_tick
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_val(CNT_W));
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nx;
  logic             sig_s, rise, fall;
  logic [CNT_W-1:0] pcnt, hcnt;
  logic             hdone;
  logic             capture;
  logic             pcnt_sat;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .sig_async(sig_in),
    .sig_s    (sig_s),
    .rise     (rise),
    .fall     (fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // A rise in the saturation cycle still closes a real period, so ovf is simply ~rise.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    pcnt_sat = (pcnt == SAT);
    if (!measure_en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: state_nx = ARM;
        ARM:  if (rise) state_nx = MEAS;
        MEAS: begin
          if (rise || pcnt_sat) begin
            state_nx = HOLD;
            capture  = 1'b1;
          end
        end
        HOLD: if (period_ready) state_nx = ARM;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign period_valid = (state == HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt      <= '0;
      hcnt      <= '0;
      hdone     <= 1'b0;
      period    <= '0;
      high_time <= '0;
      ovf       <= 1'b0;
      edge_tick <= 1'b0;
    end else begin
      edge_tick <= rise;
      if (state == ARM && rise) begin
        pcnt  <= ONE;
        hcnt  <= ONE;
        hdone <= 1'b0;
      end else if (state == MEAS) begin
        if (!rise && !pcnt_sat) pcnt <= pcnt + ONE;
        if (sig_s && !hdone && hcnt != SAT) hcnt <= hcnt + ONE;
        if (fall) hdone <= 1'b1;
      end
      if (capture) begin
        period    <= pcnt;
        high_time <= hcnt;
        ovf       <= ~rise;
      end
    end
  end

endmodule

// File: tb/tb_div_period_meter.sv
// tb/tb_div_period_meter.sv - directed vector bench for div_period_meter (12-bit and 8-bit instances)
module tb_div_period_meter;

  typedef struct {
    int hi;
    int lo;
    int exp_p;
    int exp_h;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, measure_en, period_ready, sig_in;
  logic        man_sig, gen_sig;
  bit          gen_on;
  int          gen_hi, gen_lo;
  logic        va, vb, oa, ob, ta, tb;
  logic [11:0] pa, ha;
  logic [7:0]  pb, hb;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign sig_in = gen_on ? gen_sig : man_sig;

  div_period_meter #(.CNT_W(12), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .sig_in(sig_in), .measure_en(measure_en),
    .period_ready(period_ready), .period_valid(va), .period(pa),
    .high_time(ha), .ovf(oa), .edge_tick(ta)
  );

  div_period_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .sig_in(sig_in), .measure_en(measure_en),
    .period_ready(period_ready), .period_valid(vb), .period(pb),
    .high_time(hb), .ovf(ob), .edge_tick(tb)
  );

  // Square-wave source: gen_hi cycles high, gen_lo cycles low, changed on negedges.
  initial gen_sig = 1'b0;
  always begin
    @(negedge clk);
    if (gen_on) begin
      gen_sig = 1'b1;
      repeat (gen_hi) @(negedge clk);
      gen_sig = 1'b0;
      repeat (gen_lo - 1) @(negedge clk);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic get_res(input bit use_b, input int budget,
                         output int p, output int h, output int o, output bit got);
    got = 1'b0; p = 0; h = 0; o = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (use_b ? vb : va) begin
        got = 1'b1;
        p = use_b ? int'(pb) : int'(pa);
        h = use_b ? int'(hb) : int'(ha);
        o = use_b ? int'(ob) : int'(oa);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: no period_valid within %0d cycles, required valid=1", budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   lat_exp[4];
    int   p, h, o, ticks;
    bit   got, flag;

    vecs[0] = '{hi: 8,   lo: 8,   exp_p: 16,  exp_h: 8};
    vecs[1] = '{hi: 1,   lo: 1,   exp_p: 2,   exp_h: 1};
    vecs[2] = '{hi: 128, lo: 128, exp_p: 256, exp_h: 128};
    vecs[3] = '{hi: 3,   lo: 5,   exp_p: 8,   exp_h: 3};
    vecs[4] = '{hi: 1,   lo: 2,   exp_p: 3,   exp_h: 1};
    vecs[5] = '{hi: 10,  lo: 1,   exp_p: 11,  exp_h: 10};
    vecs[6] = '{hi: 2,   lo: 1,   exp_p: 3,   exp_h: 2};
    lat_exp = '{0, 0, 1, 0};

    reset = 1'b0; man_sig = 1'b0; measure_en = 1'b0; period_ready = 1'b1;
    gen_on = 1'b0; gen_hi = 8; gen_lo = 8;

    #12;
    check("reset_valid", int'(va), 0);
    check("reset_period", int'(pa), 0);
    check("reset_high", int'(ha), 0);
    check("reset_ovf", int'(oa), 0);
    check("reset_tick", int'(ta), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // edge_tick appears on the third edge after sig_in is first sampled high
    man_sig = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("tick_latency_%0d", k), int'(ta), lat_exp[k]);
    end
    man_sig = 1'b0;
    repeat (5) @(negedge clk);

    gen_on = 1'b1;
    for (int v = 0; v < 7; v++) begin
      measure_en = 1'b0;
      gen_hi = vecs[v].hi;
      gen_lo = vecs[v].lo;
      repeat (300) @(negedge clk);
      measure_en = 1'b1;
      for (int r = 0; r < 2; r++) begin
        get_res(1'b0, 4 * vecs[v].exp_p + 40, p, h, o, got);
        if (got) begin
          check($sformatf("vec%0d_r%0d_period", v, r), p, vecs[v].exp_p);
          check($sformatf("vec%0d_r%0d_high", v, r), h, vecs[v].exp_h);
          check($sformatf("vec%0d_r%0d_ovf", v, r), o, 0);
        end
      end
    end

    // backpressure on a period-16 wave
    measure_en = 1'b0;
    gen_hi = 8; gen_lo = 8;
    repeat (300) @(negedge clk);
    period_ready = 1'b0;
    measure_en = 1'b1;
    get_res(1'b0, 100, p, h, o, got);
    if (got) begin
      check("bp_period", p, 16);
      check("bp_high", h, 8);
    end
    flag = 1'b1; ticks = 0;
    repeat (96) begin
      @(negedge clk);
      if (ta) ticks++;
      if (!va || pa != 12'd16 || ha != 12'd8 || oa) flag = 1'b0;
    end
    check("bp_hold_stable", int'(flag), 1);
    check("bp_edge_ticks", ticks, 6);
    period_ready = 1'b1;
    @(negedge clk);
    period_ready = 1'b0;
    check("bp_valid_drop", int'(va), 0);
    flag = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (va) flag = 1'b0;
    end
    check("bp_no_early_result", int'(flag), 1);
    period_ready = 1'b1;
    get_res(1'b0, 100, p, h, o, got);
    if (got) begin
      check("bp_next_period", p, 16);
      check("bp_next_high", h, 8);
    end

    // asynchronous reset while measuring
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ta) got = 1'b1;
    end
    check("rst_found_rise", int'(got), 1);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async_valid", int'(va), 0);
    check("rst_async_period", int'(pa), 0);
    check("rst_async_high", int'(ha), 0);
    check("rst_async_ovf", int'(oa), 0);
    @(negedge clk);
    reset = 1'b1;
    get_res(1'b0, 100, p, h, o, got);
    if (got) begin
      check("rst_after_period", p, 16);
      check("rst_after_high", h, 8);
    end

    // overflow on the 8-bit instance, input held high
    measure_en = 1'b0;
    gen_on = 1'b0;
    man_sig = 1'b0;
    repeat (10) @(negedge clk);
    measure_en = 1'b1;
    repeat (3) @(negedge clk);
    man_sig = 1'b1;
    get_res(1'b1, 300, p, h, o, got);
    if (got) begin
      check("ovf_hi_period", p, 255);
      check("ovf_hi_high", h, 255);
      check("ovf_hi_ovf", o, 1);
    end

    // overflow with a single-cycle pulse then held low
    measure_en = 1'b0;
    man_sig = 1'b0;
    repeat (10) @(negedge clk);
    measure_en = 1'b1;
    repeat (3) @(negedge clk);
    man_sig = 1'b1;
    @(negedge clk);
    man_sig = 1'b0;
    get_res(1'b1, 300, p, h, o, got);
    if (got) begin
      check("ovf_lo_period", p, 255);
      check("ovf_lo_high", h, 1);
      check("ovf_lo_ovf", o, 1);
    end

    // enable drop during MEAS restarts from a fresh arming rise
    measure_en = 1'b0;
    gen_hi = 32; gen_lo = 32;
    gen_on = 1'b1;
    repeat (200) @(negedge clk);
    measure_en = 1'b1;
    repeat (2) @(negedge clk);
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (ta) got = 1'b1;
    end
    check("endrop_found_rise", int'(got), 1);
    repeat (5) @(negedge clk);
    measure_en = 1'b0;
    repeat (2) @(negedge clk);
    measure_en = 1'b1;
    flag = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (va) flag = 1'b0;
    end
    check("endrop_meas_no_result", int'(flag), 1);
    get_res(1'b0, 200, p, h, o, got);
    if (got) begin
      check("endrop_meas_period", p, 64);
      check("endrop_meas_high", h, 32);
    end

    // enable drop during HOLD discards the pending result, keeps values
    period_ready = 1'b0;
    get_res(1'b0, 200, p, h, o, got);
    if (got) check("endrop_hold_period", p, 64);
    measure_en = 1'b0;
    @(negedge clk);
    check("endrop_hold_valid", int'(va), 0);
    check("endrop_hold_keep_period", int'(pa), 64);
    check("endrop_hold_keep_high", int'(ha), 32);

    // re-enable with the input already high
    gen_on = 1'b0;
    man_sig = 1'b1;
    repeat (10) @(negedge clk);
    period_ready = 1'b1;
    measure_en = 1'b1;
    flag = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (va) flag = 1'b0;
    end
    check("reen_high_no_result", int'(flag), 1);
    man_sig = 1'b0;
    repeat (5) @(negedge clk);
    man_sig = 1'b1;
    repeat (5) @(negedge clk);
    man_sig = 1'b0;
    repeat (5) @(negedge clk);
    man_sig = 1'b1;
    get_res(1'b0, 50, p, h, o, got);
    if (got) begin
      check("reen_period", p, 10);
      check("reen_high", h, 5);
      check("reen_ovf", o, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_period_meter.md
Name: div_period_meter

Overview:
- Consumes the divided-clock output of the clock divider stage. Measures its period and high time in `clk` cycles.
- The divided signal is treated as asynchronous: it is synchronised and edge-detected before measurement.
- Results are presented on a valid/ready interface to a downstream display or checker.
- Used in-system to confirm that the selected division factor is actually being produced.

Parameters:
- CNT_W, 12: width of the period and high-time counters; saturate at 2^CNT_W-1.
- SYNC_STAGES, 2: synchroniser flop count on `sig_in`; legal range 2..4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- sig_in  input  1  divided clock under measurement; asynchronous to `clk`.
- measure_en  input  1  1 = measurement enabled.
- period_ready  input  1  consumer accepts the result.
- period_valid  output  1  result pending.
- period  output  CNT_W  clk cycles between consecutive rising edges of `sig_in`.
- high_time  output  CNT_W  clk cycles `sig_in` was high within that period.
- ovf  output  1  period counter saturated; result invalid as a frequency.
- edge_tick  output  1  one-cycle pulse per synchronised rising edge; runs in every state.

Behaviour:
- Reset: asynchronous, active-low; all flops clear while `reset`=0.
  - Outputs 0: `period_valid`, `period`, `high_time`, `ovf`, `edge_tick`.
  - Synchroniser and edge history cleared; state IDLE.
- Sync/edge path:
  - `sig_in` passes through SYNC_STAGES flops to give `sig_s`, plus one history flop.
  - `rise` = `sig_s` & ~history; `fall` = ~`sig_s` & history.
  - `edge_tick` is the registered `rise`. It is high exactly one cycle, SYNC_STAGES+1 clock edges after the first edge sampling `sig_in`=1.
- State machine:
  - IDLE: if `measure_en`=1, go to ARM.
  - ARM: on `rise`, `pcnt`<=1, `hcnt`<=1, `hdone`<=0, go to MEAS.
  - MEAS, each cycle:
    - Without `rise`: `pcnt`++.
    - While `sig_s`=1 and `hdone`=0: `hcnt`++.
    - `fall` sets `hdone`.
    - On `rise`: capture `period`<=`pcnt`, `high_time`<=`hcnt`, `ovf`<=0, then go to HOLD.
    - If `pcnt`=2^CNT_W-1 without `rise`: capture `period`=all-ones, `high_time`=`hcnt`, `ovf`<=1, then go to HOLD.
  - HOLD: `period_valid`=1.
    - When `period_valid` & `period_ready`: go to ARM next cycle; `period_valid` falls the same edge.
    - Edges arriving in HOLD are ignored, and measurements never overlap. The next result needs a fresh arming rise.
- Results:
  - `period`, `high_time` and `ovf` are stable while `period_valid`=1. They retain their last values after acceptance and in IDLE.
  - `period_valid` never depends combinationally on `period_ready`. `period_ready` may be high before valid.
- Counter widths:
  - `hcnt` saturates independently at all-ones.
  - `high_time` never exceeds `period` unless `ovf`=1.
- `measure_en`=0 in any state: go to IDLE on the next edge and drop `period_valid`. A pending result is discarded; `period`, `high_time` and `ovf` keep their last values.
- `measure_en` rising while `sig_s` is already high: ARM waits for a genuine `rise`; no partial period is reported.
- Simultaneous `rise` and saturation in the same cycle: `rise` wins and `ovf`=0.
- Minimum measurable period is 2 cycles (`sig_in` toggling every `clk`), giving `period`=2, `high_time`=1.

Decomposition:
- Shared package `div_meter_pkg`:
  - State enum: IDLE, ARM, MEAS, HOLD.
  - Constant `SAT_VAL(CNT_W)`.
  - Default parameter constants.
- One sub-module, `sync_edge_det`: parameterised SYNC_STAGES synchroniser plus history flop. Outputs `sig_s`, `rise`, `fall`. Reusable by other async-input blocks.
- The FSM and counters stay in the top module.

Test Plan:
- Reset: pulse `reset`=0 mid-MEAS while `sig_in` toggles. All outputs go 0 immediately without waiting for `clk`; after release with `measure_en`=1, the first result needs a full period.
- Square wave, period 16 / high 8 `clk`, `period_ready`=1 → successive results `period`=16, `high_time`=8, `ovf`=0, with one `edge_tick` per rise.
- Fastest input, `sig_in` toggling every `clk` → `period`=2, `high_time`=1. Then period 256 / high 128 → `period`=256, `high_time`=128.
- Backpressure: `period_ready`=0 for 100 cycles on a period-16 input.
  - `period_valid` holds with values stable; edges ignored (`edge_tick` still pulses).
  - After one accept cycle, `period_valid`=0 until the next full period completes.
- Overflow with CNT_W=8: one rise then `sig_in` held high → after 255 cycles `period`=255, `high_time`=255, `ovf`=1. Held low instead → `high_time`=1.
- Enable drop: `measure_en`=0 in MEAS, and separately in HOLD → IDLE next cycle, `period_valid`=0, no result emitted. Re-enable with `sig_in` already high → no report until a true rising edge.
